// File: rtl/ov7670_pkg.sv
// Shared constants and FSM encoding for the OV7670 capture path, frame RAM and display readout.
package ov7670_pkg;

    localparam int unsigned FRAME_WIDTH  = 640;
    localparam int unsigned FRAME_HEIGHT = 480;
    localparam int unsigned ADDR_W       = 19;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2
    } cap_state_t;

endpackage

// File: rtl/ov7670_edge_detect.sv
// Single-register edge detector: holds the previous sample and flags rising/falling edges.
module ov7670_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise_c,
    output logic fall_c
);

    logic prev;

    always_ff @(posedge clk) begin
        if (rst) prev <= 1'b0;
        else     prev <= din;
    end

    assign rise_c = din & ~prev;
    assign fall_c = ~din & prev;

endmodule

// File: rtl/ov7670_capture_binarizer.sv
// OV7670 YUV422 capture: thresholds luma to 1 bit and drives the frame RAM write port.
// Optional CAPTURE_GATE_EN adds a Capture input that can skip whole frames.
module ov7670_capture_binarizer #(
    parameter int unsigned FRAME_WIDTH  = ov7670_pkg::FRAME_WIDTH,
    parameter int unsigned FRAME_HEIGHT = ov7670_pkg::FRAME_HEIGHT,
    parameter int unsigned ADDR_W       = ov7670_pkg::ADDR_W,
    parameter int unsigned LUMA_PHASE   = 0
) (
    input  logic              Clock,
    input  logic              Reset,
`ifdef CAPTURE_GATE_EN
    input  logic              Capture,
`endif
    input  logic              Vsync,
    input  logic              Href,
    input  logic [7:0]        PixData,
    input  logic [7:0]        Threshold,
    output logic              WriteEnable,
    output logic [ADDR_W-1:0] WriteAddr,
    output logic              DataIn,
    output logic              FrameDone,
    output logic              Overrun
);
    import ov7670_pkg::*;

    localparam int unsigned COL_W = $clog2(FRAME_WIDTH + 1);
    localparam int unsigned ROW_W = $clog2(FRAME_HEIGHT + 1);
    localparam logic        LUMA_BIT = 1'(LUMA_PHASE);

    cap_state_t         state;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic [ADDR_W-1:0]  line_base;
    logic [ADDR_W-1:0]  wr_ptr;
    logic               phase;
    logic               vsync_rise_c, vsync_fall_c;
    logic               href_rise_c, href_fall_c;
    logic               cur_phase_c;
    logic               capture_ok_c;

    ov7670_edge_detect u_vsync_edge (
        .clk    (Clock),
        .rst    (Reset),
        .din    (Vsync),
        .rise_c (vsync_rise_c),
        .fall_c (vsync_fall_c)
    );

    ov7670_edge_detect u_href_edge (
        .clk    (Clock),
        .rst    (Reset),
        .din    (Href),
        .rise_c (href_rise_c),
        .fall_c (href_fall_c)
    );

`ifdef CAPTURE_GATE_EN
    assign capture_ok_c = Capture;
`else
    assign capture_ok_c = 1'b1;
`endif

    // First byte of every line is phase 0 regardless of any stale phase state.
    assign cur_phase_c = href_rise_c ? 1'b0 : phase;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= IDLE;
            col         <= '0;
            row         <= '0;
            line_base   <= '0;
            wr_ptr      <= '0;
            phase       <= 1'b0;
            WriteEnable <= 1'b0;
            WriteAddr   <= '0;
            DataIn      <= 1'b0;
            FrameDone   <= 1'b0;
            Overrun     <= 1'b0;
        end else begin
            WriteEnable <= 1'b0;
            FrameDone   <= 1'b0;
            case (state)
                IDLE: begin
                    phase <= 1'b0;
                    if (Vsync) state <= SYNC;
                end
                SYNC: begin
                    phase <= 1'b0;
                    if (vsync_fall_c && capture_ok_c) begin
                        state     <= ACTIVE;
                        col       <= '0;
                        row       <= '0;
                        line_base <= '0;
                        wr_ptr    <= '0;
                        Overrun   <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (vsync_rise_c) begin
                        // Frame end takes priority over any line still in flight.
                        state     <= SYNC;
                        FrameDone <= 1'b1;
                        phase     <= 1'b0;
                    end else if (Href) begin
                        phase <= ~cur_phase_c;
                        if (cur_phase_c == LUMA_BIT) begin
                            if ((row == ROW_W'(FRAME_HEIGHT)) || (col == COL_W'(FRAME_WIDTH))) begin
                                Overrun <= 1'b1;
                            end else begin
                                WriteEnable <= 1'b1;
                                WriteAddr   <= wr_ptr;
                                DataIn      <= (PixData >= Threshold);
                                wr_ptr      <= wr_ptr + ADDR_W'(1);
                                col         <= col + COL_W'(1);
                            end
                        end
                    end else begin
                        phase <= 1'b0;
                        // Row saturates at FRAME_HEIGHT so excess lines cannot wrap the address.
                        if (href_fall_c && (row != ROW_W'(FRAME_HEIGHT))) begin
                            row       <= row + ROW_W'(1);
                            col       <= '0;
                            line_base <= line_base + ADDR_W'(FRAME_WIDTH);
                            wr_ptr    <= line_base + ADDR_W'(FRAME_WIDTH);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_capture_binarizer.sv
// Directed bench for ov7670_capture_binarizer on a reduced 8x4 frame.
module tb_ov7670_capture_binarizer;

    localparam int unsigned W  = 8;
    localparam int unsigned H  = 4;
    localparam int unsigned AW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          capture;
    logic          vsync;
    logic          href;
    logic [7:0]    pix;
    logic [7:0]    thr;
    logic          we;
    logic [AW-1:0] waddr;
    logic          din;
    logic          fdone;
    logic          ovr;

    int checks   = 0;
    int failures = 0;

    int   wr_addr_q[$];
    int   wr_data_q[$];
    logic written[64];
    int   fd_cnt  = 0;
    int   b2b_cnt = 0;
    logic we_prev = 1'b0;

    ov7670_capture_binarizer #(
        .FRAME_WIDTH  (W),
        .FRAME_HEIGHT (H),
        .ADDR_W       (AW),
        .LUMA_PHASE   (0)
    ) dut (
        .Clock       (clk),
        .Reset       (rst),
`ifdef CAPTURE_GATE_EN
        .Capture     (capture),
`endif
        .Vsync       (vsync),
        .Href        (href),
        .PixData     (pix),
        .Threshold   (thr),
        .WriteEnable (we),
        .WriteAddr   (waddr),
        .DataIn      (din),
        .FrameDone   (fdone),
        .Overrun     (ovr)
    );

    always #5 clk = ~clk;

    // Write/pulse log sampled mid-cycle.
    always @(negedge clk) begin
        if (we) begin
            wr_addr_q.push_back(int'(waddr));
            wr_data_q.push_back(int'(din));
            written[waddr] = 1'b1;
            if (we_prev) b2b_cnt++;
        end
        if (fdone) fd_cnt++;
        we_prev = we;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        for (int i = 0; i < 64; i++) written[i] = 1'b0;
        fd_cnt = 0;
    endtask

    function automatic int qa(input int i);
        return (i < wr_addr_q.size()) ? wr_addr_q[i] : -1;
    endfunction

    function automatic int qd(input int i);
        return (i < wr_data_q.size()) ? wr_data_q[i] : -1;
    endfunction

    task automatic start_frame();
        vsync = 1'b1;
        step();
        step();
        vsync = 1'b0;
        step();
        step();
    endtask

    task automatic end_frame(input logic exp_fd);
        vsync = 1'b1;
        step();
        check_eq("frame_done_pulse", 32'(fdone), 32'(exp_fd));
        step();
        check_eq("frame_done_one_cycle", 32'(fdone), 32'd0);
        step();
    endtask

    task automatic send_line(input int npix, input logic [7:0] y);
        href = 1'b1;
        for (int i = 0; i < npix; i++) begin
            pix = y;
            step();
            pix = 8'h10;
            step();
        end
        href = 1'b0;
        pix  = 8'h00;
        step();
        step();
    endtask

    initial begin
        rst = 1'b1; capture = 1'b1; vsync = 1'b0; href = 1'b0; pix = 8'h00; thr = 8'h80;
        for (int i = 0; i < 64; i++) written[i] = 1'b0;
        step();
        step();
        check_eq("rst_we",    32'(we),    32'd0);
        check_eq("rst_addr",  32'(waddr), 32'd0);
        check_eq("rst_din",   32'(din),   32'd0);
        check_eq("rst_fdone", 32'(fdone), 32'd0);
        check_eq("rst_ovr",   32'(ovr),   32'd0);
        rst = 1'b0;

        // Full frame of Y=0x80 at threshold 0x80.
        start_frame();
        clear_log();
        for (int r = 0; r < int'(H); r++) send_line(W, 8'h80);
        end_frame(1'b1);
        check_eq("full_wr_cnt", wr_addr_q.size(), W * H);
        for (int i = 0; i < int'(W * H); i++) begin
            check_eq("full_addr", qa(i), i);
            check_eq("full_data", qd(i), 1);
        end
        check_eq("full_fd_cnt", fd_cnt, 1);
        check_eq("full_ovr", 32'(ovr), 32'd0);

        // Threshold edge and one-cycle latency.
        start_frame();
        href = 1'b1;
        pix  = 8'h7F;
        check_eq("thr_we_idle", 32'(we), 32'd0);
        step();
        check_eq("thr_we_lo",   32'(we),    32'd1);
        check_eq("thr_din_lo",  32'(din),   32'd0);
        check_eq("thr_addr_lo", 32'(waddr), 32'd0);
        pix = 8'h55;
        step();
        check_eq("thr_we_chroma",   32'(we),    32'd0);
        check_eq("thr_addr_hold",   32'(waddr), 32'd0);
        pix = 8'h80;
        step();
        check_eq("thr_we_hi",   32'(we),    32'd1);
        check_eq("thr_din_hi",  32'(din),   32'd1);
        check_eq("thr_addr_hi", 32'(waddr), 32'd1);
        pix = 8'h55;
        step();
        check_eq("thr_din_hold", 32'(din), 32'd1);
        href = 1'b0;
        step();
        step();
        end_frame(1'b1);

        // Long line: 12 pixels into an 8-wide line.
        start_frame();
        clear_log();
        send_line(12, 8'h90);
        check_eq("long_ovr", 32'(ovr), 32'd1);
        send_line(2, 8'h10);
        end_frame(1'b1);
        check_eq("long_wr_cnt", wr_addr_q.size(), 10);
        for (int i = 0; i < int'(W); i++) check_eq("long_addr", qa(i), i);
        check_eq("long_line1_addr", qa(8), 8);
        check_eq("long_line1_data", qd(8), 0);
        check_eq("long_ovr_sticky", 32'(ovr), 32'd1);

        // Short line: 3 pixels then a full line.
        start_frame();
        check_eq("short_ovr_cleared", 32'(ovr), 32'd0);
        clear_log();
        send_line(3, 8'hFF);
        send_line(W, 8'h00);
        end_frame(1'b1);
        check_eq("short_wr_cnt", wr_addr_q.size(), 11);
        check_eq("short_line1_addr", qa(3), 8);
        check_eq("short_data0", qd(0), 1);
        check_eq("short_data3", qd(3), 0);
        for (int a = 3; a < int'(W); a++) check_eq("short_untouched", 32'(written[a]), 32'd0);
        check_eq("short_ovr", 32'(ovr), 32'd0);

        // Excess lines beyond FRAME_HEIGHT.
        start_frame();
        clear_log();
        for (int r = 0; r < int'(H) + 1; r++) send_line(2, 8'h80);
        end_frame(1'b1);
        check_eq("rows_wr_cnt", wr_addr_q.size(), 8);
        check_eq("rows_last_addr", qa(7), 25);
        check_eq("rows_ovr", 32'(ovr), 32'd1);

        // Vsync rising while Href high aborts the line.
        start_frame();
        clear_log();
        href = 1'b1;
        pix  = 8'h80;
        step();
        pix = 8'h10;
        step();
        pix   = 8'h80;
        vsync = 1'b1;
        step();
        check_eq("abort_we", 32'(we), 32'd0);
        check_eq("abort_fd", 32'(fdone), 32'd1);
        href = 1'b0;
        step();
        step();
        check_eq("abort_wr_cnt", wr_addr_q.size(), 1);

        // Reset mid-frame.
        start_frame();
        send_line(W, 8'h80);
        send_line(W, 8'h80);
        rst = 1'b1;
        step();
        check_eq("mid_rst_we",   32'(we),    32'd0);
        check_eq("mid_rst_addr", 32'(waddr), 32'd0);
        check_eq("mid_rst_din",  32'(din),   32'd0);
        rst = 1'b0;
        clear_log();
        send_line(4, 8'h80);
        check_eq("mid_rst_no_wr", wr_addr_q.size(), 0);
        vsync = 1'b1;
        step();
        step();
        check_eq("mid_rst_no_fd", fd_cnt, 0);
        vsync = 1'b0;
        step();
        step();
        send_line(2, 8'h80);
        end_frame(1'b1);
        check_eq("mid_rst_wr_cnt", wr_addr_q.size(), 2);
        check_eq("mid_rst_addr0", qa(0), 0);
        check_eq("mid_rst_fd_cnt", fd_cnt, 1);

`ifdef CAPTURE_GATE_EN
        // Frame skipped with Capture low, captured with Capture high.
        clear_log();
        capture = 1'b0;
        start_frame();
        send_line(2, 8'h80);
        end_frame(1'b0);
        check_eq("gate_off_wr_cnt", wr_addr_q.size(), 0);
        check_eq("gate_off_fd_cnt", fd_cnt, 0);
        capture = 1'b1;
        start_frame();
        send_line(2, 8'h80);
        end_frame(1'b1);
        check_eq("gate_on_wr_cnt", wr_addr_q.size(), 2);
        check_eq("gate_on_fd_cnt", fd_cnt, 1);
`endif

        check_eq("we_never_back_to_back", b2b_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
